// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping stage.
//   state_t      : run-control FSM encoding (IDLE, RUN, PAUSE)
//   DIGIT_W      : width of one BCD digit
//   DIGIT_LIMIT  : rollover value for hundredths, tenths and seconds units
//   TENS_LIMIT   : rollover value for seconds tens
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_LIMIT = 4'd10;
    localparam logic [DIGIT_W-1:0] TENS_LIMIT  = 4'd6;

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit of the stopwatch counter.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (digit -> 0)
//   clr   : synchronous clear (digit -> 0, takes priority over cin)
//   cin   : carry in; the digit advances by one when high
//   d     : current digit value
//   cout  : carry out, high when this digit rolls over to 0 (combinational)
module stopwatch_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = DIGIT_LIMIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               cin,
    output logic [DIGIT_W-1:0] d,
    output logic               cout
);

    logic [DIGIT_W-1:0] d_reg;
    logic [DIGIT_W-1:0] d_next;
    logic [DIGIT_W-1:0] sum;

    // The digit never holds a value at or above LIMIT, so sum can only equal
    // LIMIT when cin is high: that is exactly the rollover case.
    always_comb begin
        sum    = d_reg + DIGIT_W'(cin);
        cout   = (sum == LIMIT);
        d_next = cout ? '0 : sum;
        if (clr) begin
            d_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg <= '0;
        end else begin
            d_reg <= d_next;
        end
    end

    assign d = d_reg;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping stage: divides clk into a tick every TICK_DIV cycles
// and counts SS.cc (00.00 .. 59.99) in packed BCD under start/stop/clear.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   start_stop : one-cycle pulse toggling run/pause (starts from idle)
//   clear      : one-cycle pulse that zeroes the count and stops; beats start_stop
//   digits     : {sec_tens, sec_units, tenths, hundredths}
//   running    : high while counting
//   wrap       : one-cycle pulse after the 59.99 -> 00.00 rollover
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        wrap
);

    localparam int              PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   presc_reg;
    logic [PW-1:0]   presc_next;
    logic            wrap_reg;
    logic            tick;
    logic [4:0]      carry;

    assign tick = (state_reg == RUN) && (presc_reg == PRE_LAST);

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Prescaler holds in PAUSE so a resume keeps the partial tick period.
    always_comb begin
        presc_next = presc_reg;
        if (clear || state_reg == IDLE) begin
            presc_next = '0;
        end else if (state_reg == RUN) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            wrap_reg  <= clear ? 1'b0 : carry[4];
        end
    end

    // Ripple chain: tick feeds hundredths, each digit's carry feeds the next.
    assign carry[0] = tick;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            stopwatch_digit #(
                .LIMIT((gi == 3) ? TENS_LIMIT : DIGIT_LIMIT)
            ) u_digit (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (clear),
                .cin  (carry[gi]),
                .d    (digits[gi*DIGIT_W +: DIGIT_W]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign running = (state_reg == RUN);
    assign wrap    = wrap_reg;

endmodule
